// File: rtl/rf_writeback_buffer.sv
// rf_writeback_buffer: 4-entry in-order writeback FIFO feeding a registered register-file write port.
// Optional read forwarding from pending writes is enabled by defining RF_WB_FWD_EN.
module rf_writeback_buffer (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        WbValid,
  output logic        WbReady,
  input  logic [3:0]  WbAddr,
  input  logic [31:0] WbData,
  input  logic        Stall,
  output logic        RfLoad,
  output logic [3:0]  RfAddr,
  output logic [31:0] RfData,
  output logic [2:0]  Count,
  input  logic [3:0]  RdAddrA,
  input  logic [3:0]  RdAddrB,
  input  logic [31:0] RfOutA,
  input  logic [31:0] RfOutB,
  output logic [31:0] FwdA,
  output logic [31:0] FwdB,
  output logic        FwdHitA,
  output logic        FwdHitB
);
  logic [3:0]  q_addr [4];
  logic [31:0] q_data [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic        push, pop;
  assign WbReady = !Count[2];
  assign push    = WbValid && WbReady;
  assign pop     = (Count != 3'd0) && !Stall;
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      Count  <= 3'd0;
      RfLoad <= 1'b0;
      RfAddr <= 4'd0;
      RfData <= 32'd0;
    end else begin
      RfLoad <= pop;
      if (pop) begin
        RfAddr <= q_addr[rd_ptr];
        RfData <= q_data[rd_ptr];
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      Count <= Count + 3'(push) - 3'(pop);
    end
  end
  // Storage needs no reset: only entries counted by Count are ever read.
  always_ff @(posedge Clk) begin
    if (push) begin
      q_addr[wr_ptr] <= WbAddr;
      q_data[wr_ptr] <= WbData;
    end
  end
`ifdef RF_WB_FWD_EN
  logic [1:0] idx;
  // Scan oldest to newest so the newest matching write wins.
  always_comb begin
    FwdA    = RfOutA;
    FwdB    = RfOutB;
    FwdHitA = 1'b0;
    FwdHitB = 1'b0;
    idx     = rd_ptr;
    if (RfLoad && RfAddr == RdAddrA) begin
      FwdA    = RfData;
      FwdHitA = 1'b1;
    end
    if (RfLoad && RfAddr == RdAddrB) begin
      FwdB    = RfData;
      FwdHitB = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      idx = rd_ptr + 2'(i);
      if (3'(i) < Count && q_addr[idx] == RdAddrA) begin
        FwdA    = q_data[idx];
        FwdHitA = 1'b1;
      end
      if (3'(i) < Count && q_addr[idx] == RdAddrB) begin
        FwdB    = q_data[idx];
        FwdHitB = 1'b1;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{RdAddrA, RdAddrB};
  assign FwdA      = RfOutA;
  assign FwdB      = RfOutB;
  assign FwdHitA   = 1'b0;
  assign FwdHitB   = 1'b0;
`endif
endmodule

// File: tb/tb_rf_writeback_buffer.sv
// tb_rf_writeback_buffer: directed and random stimulus against a queue-based reference model.
module tb_rf_writeback_buffer;
  logic        Clk = 0, Clr = 1, WbValid = 0, Stall = 0;
  logic [3:0]  WbAddr = 0, RdAddrA = 0, RdAddrB = 0;
  logic [31:0] WbData = 0, RfOutA = 0, RfOutB = 0;
  logic        WbReady, RfLoad, FwdHitA, FwdHitB;
  logic [3:0]  RfAddr;
  logic [31:0] RfData, FwdA, FwdB;
  logic [2:0]  Count;
  rf_writeback_buffer dut (
    .Clk(Clk), .Clr(Clr), .WbValid(WbValid), .WbReady(WbReady), .WbAddr(WbAddr),
    .WbData(WbData), .Stall(Stall), .RfLoad(RfLoad), .RfAddr(RfAddr), .RfData(RfData),
    .Count(Count), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RfOutA(RfOutA), .RfOutB(RfOutB),
    .FwdA(FwdA), .FwdB(FwdB), .FwdHitA(FwdHitA), .FwdHitB(FwdHitB)
  );
  always #5 Clk = ~Clk;
  int vectors = 0, errors = 0;
  logic [35:0] q[$];
  logic        m_load = 0;
  logic [3:0]  m_addr = 0;
  logic [31:0] m_data = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] ref_fwd(logic [3:0] ra, logic [31:0] rf);
`ifdef RF_WB_FWD_EN
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i][35:32] == ra) return {1'b1, q[i][31:0]};
    if (m_load && m_addr == ra) return {1'b1, m_data};
`endif
    return {1'b0, rf};
  endfunction
  task automatic step(bit v, logic [3:0] a, logic [31:0] d, bit s);
    logic [32:0] fa, fb;
    bit pu, po;
    WbValid = v; WbAddr = a; WbData = d; Stall = s;
    RdAddrA = 4'($urandom_range(0, 7)); RdAddrB = 4'($urandom_range(0, 7));
    RfOutA = $urandom; RfOutB = $urandom;
    #1;
    fa = ref_fwd(RdAddrA, RfOutA);
    fb = ref_fwd(RdAddrB, RfOutB);
    check("ready", 32'(WbReady), 32'(q.size() < 4));
    check("count_pre", 32'(Count), 32'(q.size()));
    check("fwd_a", FwdA, fa[31:0]);
    check("hit_a", 32'(FwdHitA), 32'(fa[32]));
    check("fwd_b", FwdB, fb[31:0]);
    check("hit_b", 32'(FwdHitB), 32'(fb[32]));
    pu = v && q.size() < 4;
    po = q.size() > 0 && !s;
    m_load = po;
    if (po) {m_addr, m_data} = q.pop_front();
    if (pu) q.push_back({a, d});
    @(posedge Clk); #1;
    check("rf_load", 32'(RfLoad), 32'(m_load));
    check("rf_addr", 32'(RfAddr), 32'(m_addr));
    check("rf_data", RfData, m_data);
    check("count", 32'(Count), 32'(q.size()));
  endtask
  task automatic mid_reset();
    #3;
    RdAddrA = 0; RdAddrB = RfAddr; WbValid = 0;
    Clr = 1;
    #1;
    check("rst_load", 32'(RfLoad), 0);
    check("rst_addr", 32'(RfAddr), 0);
    check("rst_data", RfData, 0);
    check("rst_count", 32'(Count), 0);
    check("rst_ready", 32'(WbReady), 1);
    check("rst_hit_a", 32'(FwdHitA), 0);
    check("rst_hit_b", 32'(FwdHitB), 0);
    q.delete(); m_load = 0; m_addr = 0; m_data = 0;
    @(negedge Clk); Clr = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
  endtask
  initial begin
    #12;
    check("init_count", 32'(Count), 0);
    check("init_ready", 32'(WbReady), 1);
    check("init_load", 32'(RfLoad), 0);
    @(negedge Clk); Clr = 0;
    step(1, 8, 32'h10, 0);
    drain();
    for (int i = 0; i < 5; i++) step(1, 4'(i + 1), 32'(100 + i), 1);
    check("full_ready", 32'(WbReady), 0);
    drain();
    step(1, 1, 32'h11, 1);
    step(1, 2, 32'h22, 1);
    for (int i = 0; i < 6; i++) step(1, 4'(i), 32'h300 + 32'(i), 0);
    drain();
    step(1, 3, 32'hA, 1);
    step(1, 3, 32'hB, 1);
    RdAddrA = 3; RfOutA = 0; RdAddrB = 4; RfOutB = 32'h5555_AAAA;
    #1;
`ifdef RF_WB_FWD_EN
    check("fwd40_a", FwdA, 32'hB);
    check("fwd40_hit_a", 32'(FwdHitA), 1);
`else
    check("fwd40_a", FwdA, 0);
    check("fwd40_hit_a", 32'(FwdHitA), 0);
`endif
    check("fwd40_b", FwdB, 32'h5555_AAAA);
    check("fwd40_hit_b", 32'(FwdHitB), 0);
    drain();
    for (int i = 0; i < 4; i++) step(1, 4'(i + 4), 32'h400 + 32'(i), 1);
    step(0, 0, 0, 0);
    check("pre_rst_load", 32'(RfLoad), 1);
    check("pre_rst_count", 32'(Count), 3);
    mid_reset();
    drain();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 3);
      if (n == 200) mid_reset();
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
